// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Purpose : Shared MIPS datapath definitions. Holds the architectural
//           register indices, the write-register mux select encoding and
//           the word / register-index types.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_ADDR_W = 5;

  typedef logic [MIPS_ADDR_W-1:0] reg_idx_t;
  typedef logic [MIPS_DATA_W-1:0] word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

  // Write-register mux select: which instruction field names the destination
  localparam logic [1:0] WR_SEL_RT = 2'b00;
  localparam logic [1:0] WR_SEL_RD = 2'b01;
  localparam logic [1:0] WR_SEL_RS = 2'b10;
  localparam logic [1:0] WR_SEL_RA = 2'b11;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/reg_bank_rd_port.sv
`default_nettype none
// ============================================================================
// Module  : reg_bank_rd_port
// Purpose : One registered read port of the register bank. Selects between
//           the same-edge write data (write-first bypass), hardwired zero
//           and the stored register value, then registers the result.
// Ports   : clk        - clock, rising edge
//           reset_n    - asynchronous active-low reset
//           i_rd_idx   - register index being read
//           i_rd_data  - stored contents of register i_rd_idx
//           i_wr_en    - write enable of the bank write port
//           i_wr_idx   - write destination index
//           i_wr_data  - write data
//           o_rd_data  - registered read result (1-cycle latency)
// Rev     : 1.0  initial release
// ============================================================================
module reg_bank_rd_port
  import mips_pkg::*;
#(
  parameter int DATA_W = MIPS_DATA_W,
  parameter int ADDR_W = MIPS_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_rd_idx,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] w_next;
  logic [DATA_W-1:0] r_rd_data;

  // Write-first: a write landing on this edge is visible in the same read.
  // Writes to index 0 are ignored, so they must not be bypassed either.
  always_comb begin
    w_next = i_rd_data;
    if (i_wr_en && (i_wr_idx == i_rd_idx) && (i_wr_idx != '0)) begin
      w_next = i_wr_data;
    end else if (i_rd_idx == '0) begin
      w_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_next;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule : reg_bank_rd_port
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
// Module  : reg_bank
// Purpose : 32 x 32-bit MIPS general register file with one write port and
//           two registered read ports. $zero is hardwired to 0 and $sp is
//           loaded with SP_INIT on reset.
// Ports   : clk          - clock, rising edge
//           reset_n      - asynchronous active-low reset
//           reg_write    - write enable
//           write_reg    - write destination index (write-register mux)
//           write_data   - write data
//           read_reg_1   - read index, port 1 (rs)
//           read_reg_2   - read index, port 2 (rt)
//           read_data_1  - registered read result, port 1
//           read_data_2  - registered read result, port 2
// Rev     : 1.0  initial release
// ============================================================================
module reg_bank
  import mips_pkg::*;
#(
  parameter int DATA_W  = MIPS_DATA_W,
  parameter int ADDR_W  = MIPS_ADDR_W,
  parameter int SP_IDX  = 29,
  parameter int SP_INIT = 227
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_wr_en;

  // Index 0 is never written, so entry 0 stays at its reset value of zero.
  assign w_wr_en = reg_write && (write_reg != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
      end
    end else if (w_wr_en) begin
      r_regs[write_reg] <= write_data;
    end
  end

  reg_bank_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port_1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_rd_idx  (read_reg_1),
    .i_rd_data (r_regs[read_reg_1]),
    .i_wr_en   (reg_write),
    .i_wr_idx  (write_reg),
    .i_wr_data (write_data),
    .o_rd_data (read_data_1)
  );

  reg_bank_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port_2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_rd_idx  (read_reg_2),
    .i_rd_data (r_regs[read_reg_2]),
    .i_wr_en   (reg_write),
    .i_wr_idx  (write_reg),
    .i_wr_data (write_data),
    .o_rd_data (read_data_2)
  );

endmodule : reg_bank
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_bank
// Purpose : Self-checking bench for reg_bank using a table of directed
//           vectors plus hand-written reset and sweep sequences.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_reg_bank;

  logic        clk;
  logic        reset_n;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;

  int n_tests;
  int n_fail;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  reg_bank u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .read_reg_1  (read_reg_1),
    .read_reg_2  (read_reg_2),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%08h, required 0x%08h", name, idx, act, exp);
    end
  endtask

  // Drive after the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    reg_write  = we;
    write_reg  = wr;
    write_data = wd;
    read_reg_1 = r1;
    read_reg_2 = r2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //         we    wr     wd             r1     r2     exp1           exp2
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        5'd29, 5'd5,  32'd227,       32'h0};
    vecs[1]  = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd29, 5'd0,  32'd227,       32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd8,  32'hDEADBEEF,  32'hDEADBEEF};
    vecs[3]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,         32'h0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,         32'h0};
    vecs[5]  = '{1'b1, 5'd31, 32'h00400010, 5'd31, 5'd31, 32'h00400010,  32'h00400010};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd8,  32'h00400010,  32'hDEADBEEF};
    vecs[7]  = '{1'b0, 5'd8,  32'hFFFFFFFF, 5'd8,  5'd31, 32'hDEADBEEF,  32'h00400010};
    vecs[8]  = '{1'b1, 5'd29, 32'h00001000, 5'd29, 5'd8,  32'h00001000,  32'hDEADBEEF};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd29, 5'd29, 32'h00001000,  32'h00001000};
    vecs[10] = '{1'b1, 5'd3,  32'h00000005, 5'd8,  5'd3,  32'hDEADBEEF,  32'h00000005};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd0,  32'h00000005,  32'h0};

    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    read_reg_1 = '0;
    read_reg_2 = '0;
    reset_n    = 1'b0;
    #1;
    check("por_rd1", 0, read_data_1, 32'h0);
    check("por_rd2", 0, read_data_2, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].r1, vecs[i].r2);
      check("vec_rd1", i, read_data_1, vecs[i].exp1);
      check("vec_rd2", i, read_data_2, vecs[i].exp2);
    end

    // Asynchronous reset between edges: outputs clear with no clock edge.
    @(negedge clk);
    reg_write = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rd1", 0, read_data_1, 32'h0);
    check("async_rd2", 0, read_data_2, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 5'd0, 32'h0, 5'd8, 5'd3);
    check("post_rst_rd1", 0, read_data_1, 32'h0);
    check("post_rst_rd2", 0, read_data_2, 32'h0);
    step(1'b0, 5'd0, 32'h0, 5'd29, 5'd31);
    check("post_rst_rd1", 1, read_data_1, 32'd227);
    check("post_rst_rd2", 1, read_data_2, 32'h0);

    // Reset mid-operation, with a write held across an edge during reset.
    step(1'b1, 5'd9, 32'hAAAA5555, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    check("mid_pre_rd1", 0, read_data_1, 32'hAAAA5555);
    check("mid_pre_rd2", 0, read_data_2, 32'hAAAA5555);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = 5'd9;
    write_data = 32'h5555AAAA;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_rd1", 0, read_data_1, 32'h0);
    check("mid_rst_rd2", 0, read_data_2, 32'h0);
    @(posedge clk);
    #1;
    check("mid_rst_rd1", 1, read_data_1, 32'h0);
    check("mid_rst_rd2", 1, read_data_2, 32'h0);
    @(negedge clk);
    reset_n   = 1'b1;
    reg_write = 1'b0;
    step(1'b0, 5'd0, 32'h0, 5'd9, 5'd29);
    check("mid_post_rd1", 0, read_data_1, 32'h0);
    check("mid_post_rd2", 0, read_data_2, 32'd227);

    // Sweep: fill every register, then read complementary pairs.
    for (int i = 1; i < 32; i++) begin
      step(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0);
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check("sweep_rd1", i, read_data_1, 32'(i) * 32'h01010101);
      check("sweep_rd2", i, read_data_2, 32'(31 - i) * 32'h01010101);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_bank
`default_nettype wire
